pa_seq: RTL and testbench



---
 rtl/pa_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_pa_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pa_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pa_seq
//  Purpose  : Multi-step sequencer for the P-A ALU. Runs a 16-step
//             shift-and-add multiply (MW) and, when PA_SEQ_DIV_EN is
//             defined, a 16-step restoring divide (DW). Drives the P-A
//             strobes, ALU function and register-write controls one phase
//             per clock and samples the P-A status lines.
//  Options  : PA_SEQ_DIV_EN - include the divide path (CHK state, amb, ovf)
//  Revision : 1.0 - initial release
// ============================================================================
module pa_seq #(
    parameter int STEPS = 16
) (
    input  logic clk_sys,
    input  logic clr_,
    input  logic start,
    input  logic div,
    input  logic cancel,
    input  logic at15_,
    input  logic carry_,
    input  logic s_1,
    output logic strob1,
    output logic strob2_,
    output logic as2,
    output logic w_ac,
    output logic apb,
    output logic amb,
    output logic wx_,
    output logic eat0,
    output logic busy,
    output logic done,
    output logic ovf
);

    localparam int              c_CNT_W    = $clog2(STEPS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STEPS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_PA   = 3'd2;
    localparam logic [2:0] c_ST_PB   = 3'd3;
    localparam logic [2:0] c_ST_FIN  = 3'd5;
`ifdef PA_SEQ_DIV_EN
    localparam logic [2:0] c_ST_CHK  = 3'd4;
`endif

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic r_strob1, r_strob2_, r_as2, r_w_ac, r_apb, r_amb, r_wx_, r_eat0;
    logic r_busy, r_done, r_ovf;

    logic [2:0]         w_nxt_state;
    logic [c_CNT_W-1:0] w_nxt_cnt;
    logic w_nxt_strob1, w_nxt_strob2_, w_nxt_as2, w_nxt_w_ac, w_nxt_apb;
    logic w_nxt_amb, w_nxt_wx_, w_nxt_eat0, w_nxt_busy, w_nxt_done, w_nxt_ovf;
    logic w_go_pa;

    // w_div: latched operation select; w_qbit: quotient bit for the coming PB
    logic w_div;
    logic w_qbit;

`ifdef PA_SEQ_DIV_EN
    logic r_div, r_q_q;
    logic w_nxt_div, w_nxt_q_q;
    assign w_div  = r_div;
    assign w_qbit = r_q_q;
`else
    logic w_unused_inputs;
    assign w_div           = 1'b0;
    assign w_qbit          = 1'b0;
    assign w_unused_inputs = div ^ s_1;
`endif

    // Because outputs are registered, the phase-A controls are decided on the
    // edge that enters PA, from the status lines seen in the preceding cycle.
    // The divide quotient bit is captured at that same edge so the AC write
    // decision and the bit shifted into AT always agree.
    // Next-state and next-output decode.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_ovf     = r_ovf;
        w_nxt_busy    = 1'b0;
        w_nxt_done    = 1'b0;
        w_nxt_strob1  = 1'b0;
        w_nxt_strob2_ = 1'b1;
        w_nxt_as2     = 1'b0;
        w_nxt_w_ac    = 1'b0;
        w_nxt_apb     = 1'b0;
        w_nxt_amb     = 1'b0;
        w_nxt_wx_     = 1'b1;
        w_nxt_eat0    = 1'b0;
        w_go_pa       = 1'b0;
`ifdef PA_SEQ_DIV_EN
        w_nxt_div     = r_div;
        w_nxt_q_q     = r_q_q;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (start && !cancel) begin
                    w_nxt_state = c_ST_LOAD;
                    w_nxt_busy  = 1'b1;
                    w_nxt_cnt   = '0;
                    w_nxt_ovf   = 1'b0;
`ifdef PA_SEQ_DIV_EN
                    w_nxt_div   = div;
`endif
                end
            end
            c_ST_LOAD: begin
`ifdef PA_SEQ_DIV_EN
                if (r_div) begin
                    // Trial subtract only: AC is not written in CHK
                    w_nxt_state  = c_ST_CHK;
                    w_nxt_busy   = 1'b1;
                    w_nxt_strob1 = 1'b1;
                    w_nxt_amb    = 1'b1;
                end else begin
                    w_go_pa = 1'b1;
                end
`else
                w_go_pa = 1'b1;
`endif
            end
            c_ST_PA: begin
                // MW shifts in the adder carry produced during phase A
                w_nxt_state   = c_ST_PB;
                w_nxt_busy    = 1'b1;
                w_nxt_as2     = 1'b1;
                w_nxt_strob2_ = 1'b0;
                w_nxt_wx_     = 1'b0;
                w_nxt_eat0    = w_div ? w_qbit : ~carry_;
            end
            c_ST_PB: begin
                w_nxt_cnt = r_cnt + c_CNT_ONE;
                if (r_cnt == c_CNT_LAST) begin
                    w_nxt_state = c_ST_FIN;
                    w_nxt_done  = 1'b1;
                end else begin
                    w_go_pa = 1'b1;
                end
            end
`ifdef PA_SEQ_DIV_EN
            c_ST_CHK: begin
                // Non-negative trial result means the quotient cannot fit
                if (!s_1) begin
                    w_nxt_ovf   = 1'b1;
                    w_nxt_state = c_ST_FIN;
                    w_nxt_done  = 1'b1;
                end else begin
                    w_go_pa = 1'b1;
                end
            end
`endif
            c_ST_FIN: begin
                w_nxt_state = c_ST_IDLE;
            end
            default: begin
                w_nxt_state = c_ST_IDLE;
            end
        endcase

        if (w_go_pa) begin
            w_nxt_state  = c_ST_PA;
            w_nxt_busy   = 1'b1;
            w_nxt_strob1 = 1'b1;
            w_nxt_apb    = ~w_div & ~at15_;
            w_nxt_amb    = w_div;
            w_nxt_w_ac   = w_div ? ~s_1 : 1'b1;
`ifdef PA_SEQ_DIV_EN
            w_nxt_q_q    = ~s_1;
`endif
        end
    end

    // State and output registers; reset and cancel both return to idle values.
    always_ff @(posedge clk_sys) begin
        if (!clr_ || (cancel && (r_state != c_ST_IDLE))) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_strob1  <= 1'b0;
            r_strob2_ <= 1'b1;
            r_as2     <= 1'b0;
            r_w_ac    <= 1'b0;
            r_apb     <= 1'b0;
            r_amb     <= 1'b0;
            r_wx_     <= 1'b1;
            r_eat0    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
`ifdef PA_SEQ_DIV_EN
            r_div     <= 1'b0;
            r_q_q     <= 1'b0;
`endif
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_strob1  <= w_nxt_strob1;
            r_strob2_ <= w_nxt_strob2_;
            r_as2     <= w_nxt_as2;
            r_w_ac    <= w_nxt_w_ac;
            r_apb     <= w_nxt_apb;
            r_amb     <= w_nxt_amb;
            r_wx_     <= w_nxt_wx_;
            r_eat0    <= w_nxt_eat0;
            r_busy    <= w_nxt_busy;
            r_done    <= w_nxt_done;
            r_ovf     <= w_nxt_ovf;
`ifdef PA_SEQ_DIV_EN
            r_div     <= w_nxt_div;
            r_q_q     <= w_nxt_q_q;
`endif
        end
    end

    assign strob1  = r_strob1;
    assign strob2_ = r_strob2_;
    assign as2     = r_as2;
    assign w_ac    = r_w_ac;
    assign apb     = r_apb;
    assign amb     = r_amb;
    assign wx_     = r_wx_;
    assign eat0    = r_eat0;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pa_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pa_seq
//  Purpose  : Scoreboard bench for pa_seq. Stimulus tasks pre-generate the
//             status-line waveforms of an operation, compute the expected
//             per-operation result and queue it; a monitor collects what the
//             DUT does between start and done and compares on each done.
//             Divide checks follow PA_SEQ_DIV_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pa_seq;

`ifdef PA_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk_sys = 1'b0;
    logic clr_, start, div, cancel, at15_, carry_, s_1;
    logic strob1, strob2_, as2, w_ac, apb, amb, wx_, eat0, busy, done, ovf;

    pa_seq u_dut (
        .clk_sys (clk_sys), .clr_   (clr_),   .start (start), .div  (div),
        .cancel  (cancel),  .at15_  (at15_),  .carry_(carry_), .s_1 (s_1),
        .strob1  (strob1),  .strob2_(strob2_), .as2  (as2),   .w_ac (w_ac),
        .apb     (apb),     .amb    (amb),    .wx_   (wx_),   .eat0 (eat0),
        .busy    (busy),    .done   (done),   .ovf   (ovf)
    );

    always #5 clk_sys = ~clk_sys;

    // One record per operation: when done should appear and what happened
    typedef struct packed {
        logic [31:0] done_cyc;
        logic        ovf;
        logic [4:0]  s1_n;      // number of phase-A strobes (incl. CHK)
        logic [50:0] s1_bits;   // per strobe1 cycle: {apb, amb, w_ac}
        logic [4:0]  wx_n;      // number of AT shifts
        logic [15:0] eat_bits;  // serial-in bit of each shift
        logic [5:0]  busy_n;    // cycles with busy high
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   failed   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    // Status-line waveforms indexed by cycle offset from the start cycle
    bit at_v [0:99];
    bit s1_v [0:99];
    bit cy_v [0:99];

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle(input string name, input bit ovf_exp);
        chk(name, {strob1, strob2_, as2, w_ac, apb, amb, wx_, eat0, busy, done, ovf},
            {10'b0100001000, ovf_exp});
    endtask

    // Behaviour from the operation description: the multiplier bit used by
    // step k is the one presented just before its phase A (offset 1+2k),
    // the carry shifted in is the one seen during that phase A (offset 2+2k).
    // Divide: CHK decides from s_1 at offset 2; step k decides from s_1 at
    // offset 2+2k, and the quotient bit equals the AC write decision.
    function automatic exp_t model(input int t0, input int b, input bit d);
        exp_t e;
        e = '0;
        if (!(d && DIV_EN)) begin
            for (int k = 0; k < 16; k++) begin
                e.s1_bits[3*k +: 3] = {~at_v[b+1+2*k], 1'b0, 1'b1};
                e.eat_bits[k]       = ~cy_v[b+2+2*k];
            end
            e.s1_n = 5'd16; e.wx_n = 5'd16; e.busy_n = 6'd33;
            e.done_cyc = 32'(t0 + b + 34);
        end else begin
            e.s1_bits[2:0] = 3'b010;
            if (!s1_v[b+2]) begin
                e.ovf = 1'b1; e.s1_n = 5'd1; e.busy_n = 6'd2;
                e.done_cyc = 32'(t0 + b + 3);
            end else begin
                for (int k = 0; k < 16; k++) begin
                    e.s1_bits[3*(k+1) +: 3] = {1'b0, 1'b1, ~s1_v[b+2+2*k]};
                    e.eat_bits[k]           = ~s1_v[b+2+2*k];
                end
                e.s1_n = 5'd17; e.wx_n = 5'd16; e.busy_n = 6'd34;
                e.done_cyc = 32'(t0 + b + 35);
            end
        end
        return e;
    endfunction

    // pat: 0 random, 1 alternating, 2 random without divide overflow,
    //      3 divide overflow. cut_at>0 aborts at that offset via cancel
    //      (use_clr=0) or clr_ (use_clr=1). hold keeps start high.
    task automatic run_op(input bit d, input int pat, input bit hold,
                          input int cut_at, input bit use_clr);
        int t0;
        int last;
        for (int i = 0; i < 100; i++) begin
            at_v[i] = bit'($urandom_range(0, 1));
            s1_v[i] = bit'($urandom_range(0, 1));
            cy_v[i] = bit'($urandom_range(0, 1));
            if (pat == 1) begin
                at_v[i] = bit'((i >> 1) & 1);
                s1_v[i] = bit'((i >> 1) & 1);
            end
        end
        if (pat == 2) s1_v[2] = 1'b1;
        if (pat == 3) s1_v[2] = 1'b0;
        last = hold ? 75 : ((cut_at != 0) ? cut_at + 3 : 40);
        @(negedge clk_sys);
        t0 = cyc;
        if (cut_at == 0) begin
            sb.push_back(model(t0, 0, d));
            if (hold) sb.push_back(model(t0, 35, d));
        end
        for (int o = 0; o < last; o++) begin
            if (o > 0) @(negedge clk_sys);
            start  = hold ? (o < 69) : (o == 0);
            div    = d;
            at15_  = at_v[o];
            s_1    = s1_v[o];
            carry_ = cy_v[o];
            cancel = (cut_at != 0) && !use_clr && (o == cut_at);
            clr_   = !((cut_at != 0) && use_clr && (o == cut_at));
            if ((cut_at != 0) && (o == cut_at + 1))
                check_idle(use_clr ? "clr_abort" : "cancel_abort", 1'b0);
        end
        start  = 1'b0;
        cancel = 1'b0;
        clr_   = 1'b1;
        if (pat == 3 && cut_at == 0) chk("ovf_hold", ovf, DIV_EN);
    endtask

    // Monitor: gathers each operation's observed behaviour, compares on done
    initial begin
        exp_t obs;
        exp_t e;
        obs = '0;
        forever begin
            @(negedge clk_sys);
            if (mon_en) begin
                compared++;
                if ((strob1 && !strob2_) || (apb && amb) || (as2 && strob2_) ||
                    (!DIV_EN && (amb || ovf))) begin
                    failed++;
                    $display("FAIL control_excl: strob1=%0b strob2_=%0b as2=%0b apb=%0b amb=%0b ovf=%0b (cycle %0d)",
                             strob1, strob2_, as2, apb, amb, ovf, cyc);
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        compared++;
                        failed++;
                        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle",   64'(cyc),      64'(e.done_cyc));
                        chk("ovf",          64'(ovf),      64'(e.ovf));
                        chk("phaseA_count", 64'(obs.s1_n), 64'(e.s1_n));
                        chk("phaseA_ctrl",  64'(obs.s1_bits), 64'(e.s1_bits));
                        chk("shift_count",  64'(obs.wx_n), 64'(e.wx_n));
                        chk("eat0_bits",    64'(obs.eat_bits), 64'(e.eat_bits));
                        chk("busy_cycles",  64'(obs.busy_n), 64'(e.busy_n));
                    end
                    obs = '0;
                end else if (!busy) begin
                    obs = '0;
                end else begin
                    if (obs.busy_n != 6'h3f) obs.busy_n = obs.busy_n + 6'd1;
                    if (strob1 && obs.s1_n < 5'd17) begin
                        obs.s1_bits[3*obs.s1_n +: 3] = {apb, amb, w_ac};
                        obs.s1_n = obs.s1_n + 5'd1;
                    end
                    if (!wx_ && obs.wx_n < 5'd31) begin
                        if (obs.wx_n < 5'd16) obs.eat_bits[obs.wx_n[3:0]] = eat0;
                        obs.wx_n = obs.wx_n + 5'd1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time %0t, expected bench end", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_ = 1'b0; start = 1'b0; cancel = 1'b0; div = 1'b0;
        at15_ = 1'b1; carry_ = 1'b1; s_1 = 1'b1;
        repeat (2) @(negedge clk_sys);
        check_idle("reset_hold", 1'b0);
        clr_ = 1'b1;
        @(negedge clk_sys);
        check_idle("reset_release", 1'b0);
        mon_en = 1'b1;

        run_op(1'b0, 1, 1'b0, 0, 1'b0);   // MW, multiplier 0x5555
        run_op(1'b0, 0, 1'b0, 10, 1'b0);  // MW cancelled at cycle 10
        run_op(1'b0, 0, 1'b0, 0, 1'b0);   // full MW right after cancel
        run_op(1'b1, 3, 1'b0, 0, 1'b0);   // DW overflow
        run_op(1'b1, 1, 1'b0, 0, 1'b0);   // DW alternating s_1
        run_op(1'b1, 2, 1'b0, 0, 1'b0);   // DW random, no overflow
        run_op(1'b0, 0, 1'b1, 0, 1'b0);   // start held high across two MWs
        run_op(bit'($urandom_range(0, 1)), 2, 1'b0, 20, 1'b1); // clr_ mid-op
        for (int n = 0; n < 6; n++)
            run_op(bit'($urandom_range(0, 1)), 0, 1'b0, 0, 1'b0);

        repeat (5) @(negedge clk_sys);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
`default_nettype wire
